// File: rtl/butterfly_pipe.sv
// Two-stage pipelined radix-2 complex butterfly: c = a + w*b, d = a - w*b.
// Stage S1 registers a and the twiddle product t = w*b. Stage S2 registers
// the scaled or saturated sums. Valid/ready flow control lets the pipeline
// hold up to two transactions. A sticky overflow flag records any clamp.
module butterfly_pipe #(
    parameter int n     = 32,
    parameter int d     = 16,
    parameter int mult  = 0,
    parameter int scale = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic [n-1:0] ar,
    input  logic [n-1:0] ac,
    input  logic [n-1:0] br,
    input  logic [n-1:0] bc,
    input  logic [n-1:0] wr,
    input  logic [n-1:0] wc,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [n-1:0] cr,
    output logic [n-1:0] cc,
    output logic [n-1:0] dr,
    output logic [n-1:0] dc,
    output logic         ovf,
    input  logic         clr_ovf
);

    // Full product width, plus one guard bit so that the product sum cannot wrap.
    localparam int pw = 2 * n;
    localparam int sw = 2 * n + 1;

    // Pipeline state
    logic         s1_val;
    logic         s2_val;
    logic [n-1:0] s1_ar;
    logic [n-1:0] s1_ac;
    logic [n-1:0] s1_tr;
    logic [n-1:0] s1_tc;

    // Flow control
    logic adv1;
    logic adv2;
    logic load2;

    // Twiddle datapath
    logic signed [pw-1:0] ext_br;
    logic signed [pw-1:0] ext_bc;
    logic signed [pw-1:0] ext_wr;
    logic signed [pw-1:0] ext_wc;
    logic signed [pw-1:0] p_rr;
    logic signed [pw-1:0] p_cc;
    logic signed [pw-1:0] p_rc;
    logic signed [pw-1:0] p_cr;
    logic signed [sw-1:0] full_r;
    logic signed [sw-1:0] full_c;
    logic [n-1:0]         gen_tr;
    logic [n-1:0]         gen_tc;
    logic [n-1:0]         t_r;
    logic [n-1:0]         t_c;

    // Output datapath
    logic [n:0]   sum_cr;
    logic [n:0]   sum_cc;
    logic [n:0]   sum_dr;
    logic [n:0]   sum_dc;
    logic [n-1:0] fit_cr;
    logic [n-1:0] fit_cc;
    logic [n-1:0] fit_dr;
    logic [n-1:0] fit_dc;
    logic         any_clamp;

    // Only a window of the wide product sums is kept; the remaining bits are
    // gathered here so that discarding them is clearly deliberate.
    logic unused_bits;
    assign unused_bits = ^{full_r, full_c};

    // Narrows an (n+1)-bit sum to n bits: halve it when stage scaling is on,
    // otherwise clamp it to the signed n-bit range.
    function automatic logic [n-1:0] fit(input logic [n:0] s);
        logic [n-1:0] r;
        if (scale != 0) begin
            r = s[n:1];
        end else if (s[n] != s[n-1]) begin
            r = s[n] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
        end else begin
            r = s[n-1:0];
        end
        return r;
    endfunction

    // A sum clamps only in saturating mode, when it falls outside the n-bit range.
    function automatic logic clamps(input logic [n:0] s);
        return (scale == 0) && (s[n] != s[n-1]);
    endfunction

    // Handshake: a stage may take new data when it is empty or its content moves on.
    always_comb begin
        adv2  = !s2_val || send_rdy;
        adv1  = !s1_val || adv2;
        load2 = s1_val && adv2;
    end

    assign recv_rdy = adv1;
    assign send_val = s2_val;

    // General complex multiply with wide sums, then the arithmetic shift by d,
    // keeping the low n bits of the shifted result.
    always_comb begin
        ext_br = {{n{br[n-1]}}, br};
        ext_bc = {{n{bc[n-1]}}, bc};
        ext_wr = {{n{wr[n-1]}}, wr};
        ext_wc = {{n{wc[n-1]}}, wc};
        p_rr   = ext_br * ext_wr;
        p_cc   = ext_bc * ext_wc;
        p_rc   = ext_br * ext_wc;
        p_cr   = ext_bc * ext_wr;
        full_r = {p_rr[pw-1], p_rr} - {p_cc[pw-1], p_cc};
        full_c = {p_rc[pw-1], p_rc} + {p_cr[pw-1], p_cr};
        gen_tr = full_r[d +: n];
        gen_tc = full_c[d +: n];
    end

    // Twiddle select: trivial twiddles are plain swaps and n-bit wrapping negations.
    always_comb begin
        t_r = gen_tr;
        t_c = gen_tc;
        case (mult)
            1: begin
                t_r = br;
                t_c = bc;
            end
            2: begin
                t_r = -br;
                t_c = -bc;
            end
            3: begin
                t_r = -bc;
                t_c = br;
            end
            4: begin
                t_r = bc;
                t_c = -br;
            end
            default: begin
                t_r = gen_tr;
                t_c = gen_tc;
            end
        endcase
    end

    // Butterfly sums at n+1 bits, narrowed for the output registers.
    always_comb begin
        sum_cr    = {s1_ar[n-1], s1_ar} + {s1_tr[n-1], s1_tr};
        sum_cc    = {s1_ac[n-1], s1_ac} + {s1_tc[n-1], s1_tc};
        sum_dr    = {s1_ar[n-1], s1_ar} - {s1_tr[n-1], s1_tr};
        sum_dc    = {s1_ac[n-1], s1_ac} - {s1_tc[n-1], s1_tc};
        fit_cr    = fit(sum_cr);
        fit_cc    = fit(sum_cc);
        fit_dr    = fit(sum_dr);
        fit_dc    = fit(sum_dc);
        any_clamp = clamps(sum_cr) || clamps(sum_cc) || clamps(sum_dr) || clamps(sum_dc);
    end

    // S1: capture a and the twiddle product on accept; empty out when the content moves on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_val <= 1'b0;
            s1_ar  <= '0;
            s1_ac  <= '0;
            s1_tr  <= '0;
            s1_tc  <= '0;
        end else if (adv1) begin
            s1_val <= recv_val;
            if (recv_val) begin
                s1_ar <= ar;
                s1_ac <= ac;
                s1_tr <= t_r;
                s1_tc <= t_c;
            end
        end
    end

    // S2: output registers, held stable while the downstream stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_val <= 1'b0;
            cr     <= '0;
            cc     <= '0;
            dr     <= '0;
            dc     <= '0;
        end else if (adv2) begin
            s2_val <= s1_val;
            if (s1_val) begin
                cr <= fit_cr;
                cc <= fit_cc;
                dr <= fit_dr;
                dc <= fit_dc;
            end
        end
    end

    // Sticky overflow: a clamp on the S2 load edge takes priority over a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (load2 && any_clamp) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe. Six instances with different twiddle
// and scaling modes share one input stream; a queue-based reference model
// predicts every output, ready, valid and overflow value.
module tb_butterfly_pipe;

    localparam int N  = 32;
    localparam int D  = 16;
    localparam int NI = 6;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    typedef logic [N-1:0] word_t;

    typedef struct {
        word_t ar;
        word_t ac;
        word_t br;
        word_t bc;
        word_t wr;
        word_t wc;
        int    acceptEdge;
        bit    seen;
    } txn_t;

    typedef struct packed {
        logic  clamp;
        word_t cr;
        word_t cc;
        word_t dr;
        word_t dc;
    } res_t;

    logic  clk = 1'b0;
    logic  reset;
    logic  recvVal;
    logic  sendRdy;
    logic  clrOvf;
    word_t ar, ac, br, bc, wr, wc;
    logic  recvRdy [NI];
    logic  sendVal [NI];
    logic  ovf     [NI];
    word_t cr      [NI];
    word_t cc      [NI];
    word_t dr      [NI];
    word_t dc      [NI];

    int   testsRun  = 0;
    int   failures  = 0;
    int   edgeCount = 0;
    txn_t q[$];
    bit   expOvf [NI];
    bit   clrPending;

    function automatic int multOf(input int k);
        case (k)
            0:       return 0;
            1:       return 3;
            2, 3:    return 1;
            4:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int scaleOf(input int k);
        return (k == 3 || k == 5) ? 1 : 0;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gDut
        butterfly_pipe #(.n(N), .d(D), .mult(multOf(g)), .scale(scaleOf(g))) dut (
            .clk(clk), .reset(reset),
            .recv_val(recvVal), .recv_rdy(recvRdy[g]),
            .ar(ar), .ac(ac), .br(br), .bc(bc), .wr(wr), .wc(wc),
            .send_val(sendVal[g]), .send_rdy(sendRdy),
            .cr(cr[g]), .cc(cc[g]), .dr(dr[g]), .dc(dc[g]),
            .ovf(ovf[g]), .clr_ovf(clrOvf)
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    // Reference: complex arithmetic on wide integers, then floor-shift / clamp.
    function automatic res_t model(input int m, input int s, input txn_t t);
        logic signed [65:0] xbr, xbc, xwr, xwc, prodR, prodC;
        word_t  tr, tc;
        longint sums [4];
        longint v;
        word_t  outs [4];
        res_t   r;
        xbr   = 66'($signed(t.br));
        xbc   = 66'($signed(t.bc));
        xwr   = 66'($signed(t.wr));
        xwc   = 66'($signed(t.wc));
        prodR = (xbr * xwr - xbc * xwc) >>> D;
        prodC = (xbr * xwc + xbc * xwr) >>> D;
        case (m)
            0: begin tr = prodR[N-1:0]; tc = prodC[N-1:0]; end
            1: begin tr = t.br;  tc = t.bc;  end
            2: begin tr = -t.br; tc = -t.bc; end
            3: begin tr = -t.bc; tc = t.br;  end
            default: begin tr = t.bc; tc = -t.br; end
        endcase
        sums[0] = longint'($signed(t.ar)) + longint'($signed(tr));
        sums[1] = longint'($signed(t.ac)) + longint'($signed(tc));
        sums[2] = longint'($signed(t.ar)) - longint'($signed(tr));
        sums[3] = longint'($signed(t.ac)) - longint'($signed(tc));
        r.clamp = 1'b0;
        for (int k = 0; k < 4; k++) begin
            v = sums[k];
            if (s == 1) begin
                v = v >>> 1;
                outs[k] = v[N-1:0];
            end else if (v > MAXV) begin
                outs[k] = 32'h7FFFFFFF;
                r.clamp = 1'b1;
            end else if (v < MINV) begin
                outs[k] = 32'h80000000;
                r.clamp = 1'b1;
            end else begin
                outs[k] = v[N-1:0];
            end
        end
        r.cr = outs[0];
        r.cc = outs[1];
        r.dr = outs[2];
        r.dc = outs[3];
        return r;
    endfunction

    function automatic txn_t mkTxn(input word_t a_r, a_c, b_r, b_c, w_r, w_c);
        txn_t t;
        t.ar = a_r; t.ac = a_c; t.br = b_r; t.bc = b_c; t.wr = w_r; t.wc = w_c;
        t.acceptEdge = 0;
        t.seen = 1'b0;
        return t;
    endfunction

    function automatic word_t randWord();
        word_t r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0, 1:    return r;
            2:       return {{14{r[17]}}, r[17:0]};
            3:       return 32'h80000000;
            default: return 32'h7FFFFFFF;
        endcase
    endfunction

    task automatic checkOutput(input string name, input word_t act, input word_t exp);
        testsRun++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkFlag(input string name, input logic act, input logic exp);
        testsRun++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input word_t a_r, a_c, b_r, b_c, w_r, w_c);
        recvVal = v;
        ar = a_r; ac = a_c; br = b_r; bc = b_c; wr = w_r; wc = w_c;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Cycle-by-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        bit   expSend;
        bit   expRdy;
        bit   setNow;
        res_t r;
        txn_t t;
        if (!reset) begin
            q.delete();
            clrPending = 1'b0;
            for (int k = 0; k < NI; k++) expOvf[k] = 1'b0;
        end else begin
            expSend = (q.size() > 0) && (q[0].acceptEdge < edgeCount);
            expRdy  = (q.size() < 2) || sendRdy;
            for (int k = 0; k < NI; k++) begin
                setNow = 1'b0;
                if (expSend) begin
                    r = model(multOf(k), scaleOf(k), q[0]);
                    if (!q[0].seen) setNow = r.clamp;
                    checkOutput($sformatf("inst%0d.cr", k), cr[k], r.cr);
                    checkOutput($sformatf("inst%0d.cc", k), cc[k], r.cc);
                    checkOutput($sformatf("inst%0d.dr", k), dr[k], r.dr);
                    checkOutput($sformatf("inst%0d.dc", k), dc[k], r.dc);
                end
                expOvf[k] = setNow ? 1'b1 : (clrPending ? 1'b0 : expOvf[k]);
                checkFlag($sformatf("inst%0d.recv_rdy", k), recvRdy[k], expRdy);
                checkFlag($sformatf("inst%0d.send_val", k), sendVal[k], expSend);
                checkFlag($sformatf("inst%0d.ovf", k), ovf[k], expOvf[k]);
            end
            if (expSend) q[0].seen = 1'b1;
            clrPending = clrOvf;
            if (expSend && sendRdy) void'(q.pop_front());
            if (recvVal && expRdy) begin
                t = mkTxn(ar, ac, br, bc, wr, wc);
                t.acceptEdge = edgeCount + 1;
                q.push_back(t);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        res_t r;
        txn_t v1, vSat, vMin, vs;
        int   cnt, first, last;
        bit   seenVal [12];

        reset   = 1'b0;
        sendRdy = 1'b1;
        clrOvf  = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, '0, '0, '0);

        // Hand-computed values that pin the reference model itself.
        v1   = mkTxn(32'h00010000, 32'h0, 32'h00008000, 32'h0, 32'h0, 32'h00010000);
        vSat = mkTxn(32'h7FFF0000, 32'h0, 32'h7FFF0000, 32'h0, 32'h0, 32'h0);
        vMin = mkTxn(32'h0, 32'h0, 32'h80000000, 32'h0, 32'h0, 32'h0);
        r = model(0, 0, v1);
        checkOutput("model.m0.cc", r.cc, 32'h00008000);
        checkOutput("model.m0.dc", r.dc, 32'hFFFF8000);
        r = model(1, 0, vSat);
        checkOutput("model.sat.cr", r.cr, 32'h7FFFFFFF);
        checkFlag("model.sat.clamp", r.clamp, 1'b1);
        r = model(1, 1, vSat);
        checkOutput("model.scale.cr", r.cr, 32'h7FFF0000);
        r = model(2, 0, vMin);
        checkOutput("model.negwrap.cr", r.cr, 32'h80000000);
        checkOutput("model.negwrap.dr", r.dr, 32'h7FFFFFFF);

        // Reset state
        repeat (2) nextCycle();
        for (int k = 0; k < NI; k++) begin
            checkFlag($sformatf("rst%0d.send_val", k), sendVal[k], 1'b0);
            checkFlag($sformatf("rst%0d.ovf", k), ovf[k], 1'b0);
            checkFlag($sformatf("rst%0d.recv_rdy", k), recvRdy[k], 1'b1);
            checkOutput($sformatf("rst%0d.cr", k), cr[k], 32'h0);
            checkOutput($sformatf("rst%0d.dc", k), dc[k], 32'h0);
        end
        reset = 1'b1;

        // General and j twiddles on the same data, with two-edge latency.
        applyStimulus(1'b1, v1.ar, v1.ac, v1.br, v1.bc, v1.wr, v1.wc);
        nextCycle();
        applyStimulus(1'b0, '0, '0, '0, '0, 32'h12345678, 32'h9ABCDEF0);
        @(negedge clk);
        checkFlag("latency.edge1", sendVal[0], 1'b0);
        @(negedge clk);
        checkFlag("latency.edge2", sendVal[0], 1'b1);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("vec1.inst%0d.cr", k), cr[k], 32'h00010000);
            checkOutput($sformatf("vec1.inst%0d.cc", k), cc[k], 32'h00008000);
            checkOutput($sformatf("vec1.inst%0d.dr", k), dr[k], 32'h00010000);
            checkOutput($sformatf("vec1.inst%0d.dc", k), dc[k], 32'hFFFF8000);
        end
        nextCycle();

        // Saturation vs. scaling, then a clear of the sticky flag.
        applyStimulus(1'b1, vSat.ar, vSat.ac, vSat.br, vSat.bc, vSat.wr, vSat.wc);
        nextCycle();
        applyStimulus(1'b0, '0, '0, '0, '0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("sat.cr", cr[2], 32'h7FFFFFFF);
        checkOutput("sat.dr", dr[2], 32'h0);
        checkFlag("sat.ovf", ovf[2], 1'b1);
        checkOutput("scale.cr", cr[3], 32'h7FFF0000);
        checkOutput("scale.dr", dr[3], 32'h0);
        checkFlag("scale.ovf", ovf[3], 1'b0);
        nextCycle();
        clrOvf = 1'b1;
        nextCycle();
        clrOvf = 1'b0;
        @(negedge clk);
        checkFlag("clr.ovf", ovf[2], 1'b0);
        nextCycle();

        // Back-to-back stream of eight vectors with send_rdy held high.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(i < 8, randWord(), randWord(), randWord(), randWord(), randWord(), randWord());
            @(negedge clk);
            seenVal[i] = sendVal[0];
            nextCycle();
        end
        cnt = 0; first = -1; last = -1;
        for (int i = 0; i < 12; i++) begin
            if (seenVal[i]) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
        end
        checkOutput("b2b.count", cnt, 8);
        checkOutput("b2b.first", first, 2);
        checkOutput("b2b.last", last, 9);

        // Stall with three vectors offered, then drain.
        sendRdy = 1'b0;
        vs = mkTxn(randWord(), randWord(), randWord(), randWord(), randWord(), randWord());
        applyStimulus(1'b1, vs.ar, vs.ac, vs.br, vs.bc, vs.wr, vs.wc);
        nextCycle();
        applyStimulus(1'b1, randWord(), randWord(), randWord(), randWord(), randWord(), randWord());
        nextCycle();
        applyStimulus(1'b1, randWord(), randWord(), randWord(), randWord(), randWord(), randWord());
        r = model(0, 0, vs);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkFlag($sformatf("stall%0d.recv_rdy", i), recvRdy[0], 1'b0);
            checkFlag($sformatf("stall%0d.send_val", i), sendVal[0], 1'b1);
            checkOutput($sformatf("stall%0d.cr", i), cr[0], r.cr);
            checkOutput($sformatf("stall%0d.dc", i), dc[0], r.dc);
            nextCycle();
        end
        sendRdy = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sendVal[0]) cnt++;
            nextCycle();
            if (i == 0) applyStimulus(1'b0, '0, '0, '0, '0, '0, '0);
        end
        checkOutput("drain.count", cnt, 3);

        // Randomised traffic with random back-pressure and occasional clears.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, randWord(), randWord(), randWord(),
                          randWord(), randWord(), randWord());
            sendRdy = $urandom_range(0, 9) < 7;
            clrOvf  = $urandom_range(0, 19) == 0;
            nextCycle();
        end
        applyStimulus(1'b0, '0, '0, '0, '0, '0, '0);
        clrOvf  = 1'b0;
        sendRdy = 1'b1;
        repeat (4) nextCycle();

        // Asynchronous reset with two transactions in flight.
        sendRdy = 1'b0;
        applyStimulus(1'b1, vSat.ar, vSat.ac, vSat.br, vSat.bc, vSat.wr, vSat.wc);
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, '0, '0, '0, '0, '0, '0);
        checkFlag("preReset.ovf", ovf[2], 1'b1);
        checkFlag("preReset.recv_rdy", recvRdy[2], 1'b0);
        #2;
        reset = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            checkFlag($sformatf("asyncRst%0d.send_val", k), sendVal[k], 1'b0);
            checkFlag($sformatf("asyncRst%0d.ovf", k), ovf[k], 1'b0);
        end
        checkOutput("asyncRst.cr", cr[2], 32'h0);
        nextCycle();
        reset   = 1'b1;
        sendRdy = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sendVal[0]) cnt++;
            nextCycle();
        end
        checkOutput("postReset.stale", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
